// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for a raster-scan grayscale stream.
// Two line buffers plus a 3x3 shift register present a window around each interior pixel.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COORD_W    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         pix_in,
    input  logic               pix_valid,
    input  logic               sof,
    output logic [7:0]         P0,
    output logic [7:0]         P1,
    output logic [7:0]         P2,
    output logic [7:0]         P3,
    output logic [7:0]         P4,
    output logic [7:0]         P5,
    output logic [7:0]         P6,
    output logic [7:0]         P7,
    output logic [7:0]         P8,
    output logic               start_calculations,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               frame_done,
    output logic               busy
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t             state_reg, state_next;
    logic [COORD_W-1:0] row_reg, row_next, col_reg, col_next;
    logic [COORD_W-1:0] row_cur, col_cur;
    logic               accept, at_line_end, at_fill_end, at_frame_end, win_ready;
    logic [AW-1:0]      lb_addr;
    logic [7:0]         col_new [0:2];

    // lb1 holds the previous row, lb0 the row before that
    logic [7:0] lb0 [0:IMG_WIDTH-1];
    logic [7:0] lb1 [0:IMG_WIDTH-1];

    logic start_reg, done_reg;
    logic [COORD_W-1:0] win_row_reg, win_col_reg;

    // A sof pixel is always taken as (0,0), whatever the counters say.
    always_comb begin
        accept       = pix_valid && (sof || (state_reg != IDLE));
        row_cur      = sof ? '0 : row_reg;
        col_cur      = sof ? '0 : col_reg;
        lb_addr      = col_cur[AW-1:0];
        at_line_end  = (col_cur == LAST_COL);
        at_fill_end  = at_line_end && (row_cur == ONE);
        at_frame_end = at_line_end && (row_cur == LAST_ROW);
        win_ready    = (row_cur >= TWO) && (col_cur >= TWO);
        col_new[0]   = lb0[lb_addr];
        col_new[1]   = lb1[lb_addr];
        col_new[2]   = pix_in;
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        if (accept) begin
            if (at_line_end) begin
                col_next = '0;
                row_next = at_frame_end ? '0 : row_cur + ONE;
            end else begin
                col_next = col_cur + ONE;
                row_next = row_cur;
            end
            if (sof) begin
                state_next = FILL;
            end else begin
                case (state_reg)
                    FILL:    if (at_fill_end)  state_next = STREAM;
                    STREAM:  if (at_frame_end) state_next = IDLE;
                    default: state_next = state_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
        end
    end

    // Line buffers keep their contents across reset and frames.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[lb_addr] <= lb1[lb_addr];
            lb1[lb_addr] <= pix_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [7:0] tap_reg [0:2];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tap_reg[0] <= '0;
                    tap_reg[1] <= '0;
                    tap_reg[2] <= '0;
                end else if (accept) begin
                    tap_reg[0] <= tap_reg[1];
                    tap_reg[1] <= tap_reg[2];
                    tap_reg[2] <= col_new[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_reg   <= 1'b0;
            done_reg    <= 1'b0;
            win_row_reg <= '0;
            win_col_reg <= '0;
        end else begin
            start_reg <= accept && win_ready;
            done_reg  <= accept && !sof && (state_reg == STREAM) && at_frame_end;
            if (accept && win_ready) begin
                win_row_reg <= row_cur - ONE;
                win_col_reg <= col_cur - ONE;
            end
        end
    end

    assign P0 = g_row[0].tap_reg[0];
    assign P1 = g_row[0].tap_reg[1];
    assign P2 = g_row[0].tap_reg[2];
    assign P3 = g_row[1].tap_reg[0];
    assign P4 = g_row[1].tap_reg[1];
    assign P5 = g_row[1].tap_reg[2];
    assign P6 = g_row[2].tap_reg[0];
    assign P7 = g_row[2].tap_reg[1];
    assign P8 = g_row[2].tap_reg[2];

    assign start_calculations = start_reg;
    assign frame_done         = done_reg;
    assign win_row            = win_row_reg;
    assign win_col            = win_col_reg;
    assign busy               = (state_reg != IDLE);

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image: an image-array model predicts every window,
// plus literal windows for the first pulse, row wrap and restart cases.
module tb_sobel_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    pix_in = 8'h00;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [7:0]    P0, P1, P2, P3, P4, P5, P6, P7, P8;
    logic          start_calculations, frame_done, busy;
    logic [CW-1:0] win_row, win_col;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8),
        .start_calculations(start_calculations), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [79:0] dut_vec;
    assign dut_vec = {win_row, win_col, P0, P1, P2, P3, P4, P5, P6, P7, P8};

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse = 0;
    int n_fd = 0;
    bit run = 0;
    logic [79:0] pulses_q[$];
    logic [79:0] ref_q[$];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h (t=%0t)", name, act, $time);
        end
    endtask

    // Model: the current frame is kept as an image; each interior pixel yields its 3x3 neighbourhood.
    logic [7:0]  img [0:H-1][0:W-1];
    int          m_r = 0, m_c = 0;
    bit          m_active = 0, exp_pulse = 0, exp_fd = 0, win_known = 1;
    logic [79:0] exp_vec = '0;

    always @(posedge clk or posedge reset) begin
        int r, c;
        if (reset) begin
            m_active = 0; m_r = 0; m_c = 0;
            exp_pulse = 0; exp_fd = 0; win_known = 1; exp_vec = '0;
        end else begin
            exp_pulse = 0;
            exp_fd = 0;
            if (pix_valid && (sof || m_active)) begin
                if (sof) begin
                    r = 0; c = 0; m_active = 1;
                end else begin
                    r = m_r; c = m_c;
                end
                img[r][c] = pix_in;
                if (r >= 2 && c >= 2) begin
                    exp_pulse = 1;
                    win_known = 1;
                    exp_vec = {4'(r-1), 4'(c-1),
                               img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                               img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                               img[r][c-2],   img[r][c-1],   img[r][c]};
                end else begin
                    win_known = 0;
                end
                if (r == H-1 && c == W-1) begin
                    m_active = 0; exp_fd = 1; m_r = 0; m_c = 0;
                end else if (c == W-1) begin
                    m_r = r + 1; m_c = 0;
                end else begin
                    m_r = r; m_c = c + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("start_calculations", 80'(start_calculations), 80'(exp_pulse));
            check("frame_done", 80'(frame_done), 80'(exp_fd));
            check("busy", 80'(busy), 80'(m_active));
            if (win_known) check("window", dut_vec, exp_vec);
            if (start_calculations) begin
                n_pulse++;
                pulses_q.push_back(dut_vec);
            end
            if (frame_done) n_fd++;
        end
    end

    task automatic send_pix(input logic [7:0] v, input logic s);
        @(posedge clk); #2;
        pix_in = v; pix_valid = 1'b1; sof = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            pix_in = 8'hee; pix_valid = 1'b0; sof = 1'b0;
        end
    endtask

    // Raster indices first..last of a frame; index 0 carries sof.
    task automatic send_frame(input int gap, input logic [7:0] base, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_pix(base + 8'(16 * (i / W) + (i % W)), i == 0);
            if (gap > 0) idle(gap);
        end
    endtask

    localparam logic [79:0] WIN_11 = {4'd1, 4'd1, 8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    localparam logic [79:0] WIN_21 = {4'd2, 4'd1, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
    localparam logic [79:0] WIN_22 = {4'd2, 4'd2, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};

    initial begin
        int p_base, f_base;
        logic stale;

        repeat (2) @(posedge clk);
        #1;
        check("reset_window", dut_vec, 80'd0);
        check("reset_flags", 80'({start_calculations, frame_done, busy}), 80'd0);
        #1;
        reset = 1'b0;
        run = 1;

        // Continuous full frame
        pulses_q.delete();
        p_base = n_pulse; f_base = n_fd;
        send_frame(0, 8'h00, 0, 15);
        idle(3);
        check("s1_pulse_count", 80'(n_pulse - p_base), 80'd4);
        check("s1_frame_done_count", 80'(n_fd - f_base), 80'd1);
        check("s1_first_window", pulses_q[0], WIN_11);
        check("s1_row_wrap_window", pulses_q[2], WIN_21);
        check("s1_last_window", pulses_q[3], WIN_22);
        ref_q = pulses_q;

        // pix_valid toggling every cycle
        pulses_q.delete();
        p_base = n_pulse; f_base = n_fd;
        send_frame(1, 8'h00, 0, 15);
        idle(3);
        check("s2_pulse_count", 80'(n_pulse - p_base), 80'd4);
        check("s2_frame_done_count", 80'(n_fd - f_base), 80'd1);
        for (int i = 0; i < 4; i++) check("s2_same_window", pulses_q[i], ref_q[i]);

        // sof reasserted at (2,1): old frame marked with bit 7 set
        pulses_q.delete();
        p_base = n_pulse; f_base = n_fd;
        send_frame(0, 8'h80, 0, 8);
        send_frame(0, 8'h00, 0, 15);
        idle(3);
        check("s3_pulse_count", 80'(n_pulse - p_base), 80'd4);
        check("s3_frame_done_count", 80'(n_fd - f_base), 80'd1);
        check("s3_first_window", pulses_q[0], WIN_11);
        for (int i = 0; i < pulses_q.size(); i++) begin
            stale = 1'b0;
            for (int b = 0; b < 9; b++) stale = stale | pulses_q[i][8*b+7];
            check("s3_no_stale_pixel", 80'(stale), 80'd0);
        end

        // sof arrives on the last pixel of a frame
        pulses_q.delete();
        p_base = n_pulse; f_base = n_fd;
        send_frame(0, 8'h40, 0, 14);
        send_pix(8'h00, 1'b1);
        idle(2);
        check("s4_no_frame_done", 80'(n_fd - f_base), 80'd0);
        check("s4_still_busy", 80'(busy), 80'd1);
        send_frame(0, 8'h00, 1, 15);
        idle(3);
        check("s4_pulse_count", 80'(n_pulse - p_base), 80'd7);
        check("s4_frame_done_count", 80'(n_fd - f_base), 80'd1);
        check("s4_restart_window", pulses_q[3], WIN_11);

        // Asynchronous reset mid-frame, just after the (2,2) pulse is launched
        send_frame(0, 8'h00, 0, 10);
        @(posedge clk); #3;
        reset = 1'b1; pix_valid = 1'b0;
        #1;
        check("s5_async_reset_window", dut_vec, 80'd0);
        check("s5_async_reset_flags", 80'({start_calculations, frame_done, busy}), 80'd0);
        #10;
        reset = 1'b0;

        // Pixels without sof are ignored, then a proper frame
        p_base = n_pulse; f_base = n_fd;
        send_frame(0, 8'h00, 1, 15);
        idle(2);
        check("s6_idle_no_pulses", 80'(n_pulse - p_base), 80'd0);
        check("s6_idle_not_busy", 80'(busy), 80'd0);
        pulses_q.delete();
        send_frame(0, 8'h00, 0, 15);
        idle(3);
        check("s6_pulse_count", 80'(n_pulse - p_base), 80'd4);
        check("s6_frame_done_count", 80'(n_fd - f_base), 80'd1);
        check("s6_first_window", pulses_q[0], WIN_11);

        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
